// File: rtl/chi_pkg.sv
// CHI types shared by the SN-F link-layer blocks: a reduced REQ flit plus opcode constants.
package chi_pkg;

  localparam int unsigned CHI_MAX_SRCID_RANGE = 128;
  localparam int unsigned NODEID_W = $clog2(CHI_MAX_SRCID_RANGE);

  typedef logic [5:0] req_opcode_t;

  localparam req_opcode_t REQ_LCRDRETURN     = 6'h00;
  localparam req_opcode_t REQ_READNOSNP      = 6'h04;
  localparam req_opcode_t REQ_WRITENOSNPFULL = 6'h1D;

  typedef struct packed {
    logic [3:0]          qos;
    logic [NODEID_W-1:0] tgt_id;
    logic [NODEID_W-1:0] src_id;
    logic [7:0]          txn_id;
    req_opcode_t         opcode;
    logic [2:0]          size;
    logic [47:0]         addr;
  } reqflit_t;

endpackage

// File: rtl/chi_flit_fifo.sv
// Type-generic flit FIFO; head is read straight from storage so it is stable until popped.
module chi_flit_fifo #(
  parameter type         flit_t = logic,
  parameter int unsigned Depth  = 4,
  localparam int unsigned CntW  = $clog2(Depth + 1)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            push_i,
  input  flit_t           data_i,
  input  logic            pop_i,
  output flit_t           head_o,
  output logic [CntW-1:0] count_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;

  flit_t           mem_q [Depth];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;

  // Explicit wrap keeps non-power-of-two depths inside the array.
  function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] ptr);
    return (ptr == PtrW'(Depth - 1)) ? '0 : ptr + PtrW'(1);
  endfunction

  always_comb begin
    wr_ptr_d = push_i ? next_ptr(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop_i ? next_ptr(rd_ptr_q) : rd_ptr_q;
    count_d  = count_q + CntW'(push_i) - CntW'(pop_i);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= data_i;
      end
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/snf_rxreq.sv
// SN-F receive side of the CHI REQ channel: L-credit issue, LCrdReturn filter, protocol error flag.
module snf_rxreq
  import chi_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic     clock,
  input  logic     reset,
  input  reqflit_t RXREQFLIT,
  input  logic     RXREQFLITV,
  input  logic     RXREQFLITPEND,
  output logic     RXREQLCRDV,
  input  logic     link_active,
  output reqflit_t rxreqflit,
  output logic     rxreq_valid,
  input  logic     rxreq_ready,
  output logic     lcrd_idle,
  output logic     proto_err
);

  localparam int unsigned CntW = $clog2(DEPTH + 1);

  logic [CntW-1:0] lcrd_out_q, lcrd_out_d;
  logic            lcrdv_q, proto_err_q;
  logic [CntW-1:0] count;
  logic [CntW:0]   credit_sum;
  logic            consume, push, pop, grant;
  logic            unused_pend;

  assign unused_pend = RXREQFLITPEND;

  always_comb begin
    consume    = RXREQFLITV && (lcrd_out_q != '0);
    push       = consume && (RXREQFLIT.opcode != REQ_LCRDRETURN);
    pop        = rxreq_valid && rxreq_ready;
    // A flit stored this cycle still holds its credit in lcrd_out_q, so the sum is conservative.
    credit_sum = {1'b0, lcrd_out_q} + {1'b0, count} + (CntW + 1)'(push) - (CntW + 1)'(pop);
    grant      = link_active && (credit_sum < (CntW + 1)'(DEPTH));
    lcrd_out_d = lcrd_out_q + CntW'(grant) - CntW'(consume);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      lcrd_out_q  <= '0;
      lcrdv_q     <= 1'b0;
      proto_err_q <= 1'b0;
    end else begin
      lcrd_out_q <= lcrd_out_d;
      lcrdv_q    <= grant;
      if (RXREQFLITV && (lcrd_out_q == '0)) begin
        proto_err_q <= 1'b1;
      end
    end
  end

  chi_flit_fifo #(
    .flit_t (reqflit_t),
    .Depth  (DEPTH)
  ) u_fifo (
    .clk_i   (clock),
    .rst_ni  (reset),
    .push_i  (push),
    .data_i  (RXREQFLIT),
    .pop_i   (pop),
    .head_o  (rxreqflit),
    .count_o (count)
  );

  assign RXREQLCRDV  = lcrdv_q;
  assign rxreq_valid = (count != '0);
  assign lcrd_idle   = (lcrd_out_q == '0);
  assign proto_err   = proto_err_q;

endmodule

// File: tb/tb_snf_rxreq.sv
// Directed bench for snf_rxreq with a transmitter-side credit model and a pop scoreboard.
module tb_snf_rxreq;
  import chi_pkg::*;

  localparam int unsigned DEPTH = 4;

  logic     clock = 1'b0;
  logic     reset = 1'b0;
  logic     link_active = 1'b0;
  logic     flitv = 1'b0;
  logic     pend = 1'b0;
  logic     ready = 1'b0;
  reqflit_t flit = '0;
  logic     lcrdv, valid, idle, perr;
  reqflit_t head;

  int       checks = 0;
  int       errors = 0;
  reqflit_t exp_q[$];
  reqflit_t exp_f;
  int       m_crd = 0;
  int       m_cnt = 0;
  logic     m_err = 1'b0;
  logic     chk_en = 1'b0;
  int       both_cnt = 0;
  logic [7:0] pat;
  int       n;

  always #5 clock = ~clock;

  snf_rxreq #(
    .DEPTH (DEPTH)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .RXREQFLIT     (flit),
    .RXREQFLITV    (flitv),
    .RXREQFLITPEND (pend),
    .RXREQLCRDV    (lcrdv),
    .link_active   (link_active),
    .rxreqflit     (head),
    .rxreq_valid   (valid),
    .rxreq_ready   (ready),
    .lcrd_idle     (idle),
    .proto_err     (perr)
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic reqflit_t mk(input req_opcode_t op, input logic [7:0] txn);
    reqflit_t f;
    f        = '0;
    f.opcode = op;
    f.txn_id = txn;
    f.src_id = 7'h05;
    f.tgt_id = 7'h21;
    f.size   = 3'd6;
    f.addr   = {34'h0, txn, 6'h0};
    return f;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send(input reqflit_t f);
    flitv = 1'b1;
    flit  = f;
    if (f.opcode != REQ_LCRDRETURN && m_crd > 0) exp_q.push_back(f);
    tick();
    flitv = 1'b0;
  endtask

  // Transmitter view: credits received minus credits spent, and expected FIFO occupancy.
  always @(posedge clock) begin
    if (!reset) begin
      m_crd <= 0;
      m_cnt <= 0;
      m_err <= 1'b0;
    end else begin
      m_crd <= m_crd + (lcrdv ? 1 : 0) - ((flitv && m_crd != 0) ? 1 : 0);
      m_cnt <= m_cnt + ((flitv && m_crd != 0 && flit.opcode != REQ_LCRDRETURN) ? 1 : 0)
                     - ((valid && ready) ? 1 : 0);
      if (flitv && m_crd == 0) m_err <= 1'b1;
    end
  end

  always @(negedge clock) begin
    if (chk_en) begin
      check("lcrd_idle", 128'(idle), 128'(m_crd == 0 && !lcrdv));
      check("proto_err", 128'(perr), 128'(m_err));
      check("rxreq_valid", 128'(valid), 128'(m_cnt != 0));
      check("credit_bound", 128'(m_crd + (lcrdv ? 1 : 0) + m_cnt <= DEPTH), 128'(1));
      if (flitv && m_crd != 0 && valid && ready) both_cnt++;
      if (valid && ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL pop_flit: got txn %0h expected no flit", head.txn_id);
        end else begin
          exp_f = exp_q.pop_front();
          check("pop_flit", 128'(head), 128'(exp_f));
        end
      end
    end
  end

  initial begin
    link_active = 1'b1;
    repeat (3) tick();
    check("rst_lcrdv", 128'(lcrdv), 128'(0));
    check("rst_valid", 128'(valid), 128'(0));
    check("rst_flit", 128'(head), 128'(0));
    check("rst_idle", 128'(idle), 128'(1));
    check("rst_perr", 128'(perr), 128'(0));

    // Reset release: DEPTH back-to-back credits.
    reset  = 1'b1;
    chk_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      pat[i] = lcrdv;
    end
    check("initial_credits", 128'(pat), 128'(8'h0F));
    check("idle_after_grant", 128'(idle), 128'(0));

    // Fill the FIFO with downstream stalled.
    ready = 1'b0;
    for (int t = 0; t < 4; t++) send(mk(REQ_READNOSNP, 8'(t)));
    n = 0;
    repeat (3) begin
      tick();
      n += lcrdv ? 1 : 0;
    end
    check("full_no_credit", 128'(n), 128'(0));
    check("full_valid", 128'(valid), 128'(1));
    check("full_head_txn", 128'(head.txn_id), 128'(0));

    // Drain: one credit the cycle after each pop.
    ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      pat[i] = lcrdv;
    end
    check("pop_credits", 128'(pat), 128'(8'h0F));
    check("drained_valid", 128'(valid), 128'(0));

    // LCrdReturn is swallowed and replaced one cycle later.
    send(mk(REQ_LCRDRETURN, 8'hAA));
    check("lcrdret_no_same_grant", 128'(lcrdv), 128'(0));
    tick();
    check("lcrdret_replacement", 128'(lcrdv), 128'(1));
    check("lcrdret_not_stored", 128'(valid), 128'(0));
    repeat (2) tick();

    // Deactivation: return every credit, expect none reissued.
    link_active = 1'b0;
    tick();
    n = 0;
    for (int i = 0; i < 4; i++) begin
      check("deact_not_idle_yet", 128'(idle), 128'(0));
      send(mk(REQ_LCRDRETURN, 8'(8'h10 + i)));
      n += lcrdv ? 1 : 0;
    end
    check("deact_idle", 128'(idle), 128'(1));
    repeat (3) begin
      tick();
      n += lcrdv ? 1 : 0;
    end
    check("deact_no_credit", 128'(n), 128'(0));

    // Arrivals with no credit outstanding.
    flitv = 1'b1;
    flit  = mk(REQ_READNOSNP, 8'h55);
    tick();
    check("proto_err_set", 128'(perr), 128'(1));
    repeat (2) tick();
    flitv = 1'b0;
    tick();
    check("proto_err_sticky", 128'(perr), 128'(1));
    check("proto_err_no_store", 128'(valid), 128'(0));

    // Mid-operation reset, then steady-state traffic.
    reset = 1'b0;
    repeat (2) tick();
    check("reset_clears_err", 128'(perr), 128'(0));
    link_active = 1'b1;
    reset       = 1'b1;
    tick();
    for (int i = 0; i < 80; i++) begin
      ready = (i % 7) != 3;
      if (m_crd > 0) begin
        if (i % 11 == 5) flit = mk(REQ_LCRDRETURN, 8'(i));
        else flit = mk((i % 2 == 1) ? REQ_WRITENOSNPFULL : REQ_READNOSNP, 8'(i));
        flitv = 1'b1;
        if (flit.opcode != REQ_LCRDRETURN) exp_q.push_back(flit);
      end else begin
        flitv = 1'b0;
      end
      tick();
    end
    flitv = 1'b0;
    ready = 1'b1;
    repeat (10) tick();
    check("drain_scoreboard", 128'(exp_q.size()), 128'(0));
    check("concurrent_arrival_pop", 128'(both_cnt > 0), 128'(1));
    chk_en = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
